// File: rtl/akarin_pkg.sv
// Shared types for the Akarin fetch path: queue entry layout, PC stride and fetch-queue FSM states.
package akarin_pkg;

  localparam int unsigned AKARIN_XLEN = 32;
  localparam int unsigned INST_BYTES  = 4;

  typedef struct packed {
    logic [AKARIN_XLEN-1:0] pc;
    logic [AKARIN_XLEN-1:0] inst;
  } fetchq_entry_t;

  typedef enum logic [0:0] {
    FQ_RUN   = 1'b0,
    FQ_DRAIN = 1'b1
  } fetchq_state_e;

  function automatic logic [AKARIN_XLEN-1:0] fq_next_pc(input logic [AKARIN_XLEN-1:0] pc);
    return pc + AKARIN_XLEN'(INST_BYTES);
  endfunction

endpackage

// File: rtl/akarin_fetchq_buf.sv
// Circular DEPTH-entry fetch buffer with first-word fall-through head and synchronous flush.
// Push-to-head latency one cycle; the caller guarantees no push at full unless popping.
module akarin_fetchq_buf
  import akarin_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_flush,
  input  logic          i_push,
  input  fetchq_entry_t i_push_dat,
  input  logic          i_pop,
  output logic          o_vld,
  output fetchq_entry_t o_head,
  output logic [CW-1:0] o_count
);

  fetchq_entry_t r_mem [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_vld     = (r_count != '0);
  assign w_do_push = i_push && !i_flush;
  assign w_do_pop  = i_pop && o_vld && !i_flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_tail <= r_tail + AW'(1);
      if (w_do_pop)  r_head <= r_head + AW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_tail] <= i_push_dat;
  end

  // Empty queue presents zeros rather than stale storage.
  assign o_head  = o_vld ? r_mem[r_head] : '0;
  assign o_count = r_count;

  assert property (@(posedge clk) disable iff (!rst)
    !(w_do_push && !w_do_pop && r_count == CW'(DEPTH)));

endmodule

// File: rtl/akarin_fetch_queue.sv
// Instruction prefetch queue: credit-limited memory requests, in-order fill, redirect with stale-response drain.
// rvalid to inst_valid_o is one cycle; decode backpressure (ready/stall) stops issue via the occupancy credit.
module akarin_fetch_queue
  import akarin_pkg::*;
#(
  parameter  int               XLEN            = 32,
  parameter  int               DEPTH           = 4,
  parameter  int               MAX_OUTSTANDING = 2,
  parameter  logic [XLEN-1:0]  RESET_PC        = '0,
  localparam int               CW              = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            mem_req_o,
  output logic [XLEN-1:0] mem_addr_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic            inst_valid_o,
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] inst_pc_o,
  input  logic            inst_ready_i,
  output logic [CW-1:0]   count_o
);

  localparam logic [0:0] S_RUN   = FQ_RUN;
  localparam logic [0:0] S_DRAIN = FQ_DRAIN;

  logic [0:0]      r_state;
  logic            r_req;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_resp_pc;
  logic [CW-1:0]   r_out;
  logic [CW-1:0]   r_discard;

  logic            w_gnt;
  logic            w_run;
  logic            w_push;
  logic            w_pop;
  logic            w_vld;
  logic            w_credit;
  logic            w_req_nxt;
  logic [0:0]      w_state_nxt;
  logic [CW-1:0]   w_discard_nxt;
  logic [CW-1:0]   w_out_nxt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [CW-1:0]   w_count;
  fetchq_entry_t   w_head;
  fetchq_entry_t   w_push_dat;

  assign w_gnt  = r_req && mem_gnt_i;
  assign w_run  = (r_state == S_RUN);
  assign w_push = mem_rvalid_i && w_run && !redirect_i;
  assign w_pop  = w_vld && inst_ready_i && !stall && !redirect_i;

  assign w_out_nxt = r_out + CW'(w_gnt) - CW'(mem_rvalid_i);
  assign w_cnt_nxt = redirect_i ? '0 : (w_count + CW'(w_push) - CW'(w_pop));

  // Every in-flight response at redirect time belongs to the old stream.
  always_comb begin
    w_discard_nxt = r_discard;
    w_state_nxt   = r_state;
    if (redirect_i) begin
      w_discard_nxt = w_out_nxt;
      w_state_nxt   = (w_out_nxt != '0) ? S_DRAIN : S_RUN;
    end else if (!w_run && mem_rvalid_i) begin
      w_discard_nxt = r_discard - CW'(1);
      if (r_discard == CW'(1)) w_state_nxt = S_RUN;
    end
  end

  // Credit is judged on next-cycle occupancy so back-to-back grants never overbook the buffer.
  assign w_credit = (w_state_nxt == S_RUN)
                 && ((CW+1)'(w_cnt_nxt) + (CW+1)'(w_out_nxt) < (CW+1)'(DEPTH))
                 && (w_out_nxt < CW'(MAX_OUTSTANDING));
  assign w_req_nxt = redirect_i ? w_credit : ((r_req && !mem_gnt_i) || w_credit);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_RUN;
      r_req      <= 1'b0;
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_out      <= '0;
      r_discard  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_req     <= w_req_nxt;
      r_out     <= w_out_nxt;
      r_discard <= w_discard_nxt;
      if (redirect_i) begin
        r_fetch_pc <= redirect_pc_i;
        r_resp_pc  <= redirect_pc_i;
      end else begin
        if (w_gnt)  r_fetch_pc <= fq_next_pc(r_fetch_pc);
        if (w_push) r_resp_pc  <= fq_next_pc(r_resp_pc);
      end
    end
  end

  assign w_push_dat = '{pc: r_resp_pc, inst: mem_rdata_i};

  akarin_fetchq_buf #(
    .DEPTH (DEPTH)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .i_flush    (redirect_i),
    .i_push     (w_push),
    .i_push_dat (w_push_dat),
    .i_pop      (w_pop),
    .o_vld      (w_vld),
    .o_head     (w_head),
    .o_count    (w_count)
  );

  assign mem_req_o    = r_req;
  assign mem_addr_o   = r_fetch_pc;
  assign inst_valid_o = w_vld;
  assign inst_o       = w_head.inst;
  assign inst_pc_o    = w_head.pc;
  assign count_o      = w_count;

  assert property (@(posedge clk) disable iff (!rst) !(mem_rvalid_i && r_out == '0));

endmodule
